// File: rtl/load_store_unit.sv
// Load/store unit: checks and issues one RV32I data access at a time on a req/gnt/rvalid memory bus.
// Stores take REQ->RESP and loads take REQ->WAIT->RESP; faults skip the bus; the core is stalled (cpu_ready low) until RESP.
module load_store_unit #(
    parameter logic [31:0] DMEM_START     = 32'h00200000,
    parameter logic [31:0] DMEM_END       = 32'h00250000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [1:0]  resp_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  cause_q, cause_d;

    logic        illegal, misaligned, out_of_range;
    logic [1:0]  chk_cause;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata_rep, shifted, load_ext;
    logic        timeout_hit;

    // Checks run on the live request so the fault cause is known at accept.
    always_comb begin
        illegal = 1'b0;
        if (cpu_we) begin
            illegal = !(cpu_funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            illegal = cpu_funct3 inside {3'b011, 3'b110, 3'b111};
        end
        misaligned   = ((cpu_funct3[1:0] == 2'b01) && cpu_addr[0]) ||
                       ((cpu_funct3[1:0] == 2'b10) && (cpu_addr[1:0] != 2'b00));
        out_of_range = (cpu_addr < DMEM_START) || (cpu_addr >= DMEM_END);
        if (illegal || misaligned) begin
            chk_cause = 2'd1;
        end else if (out_of_range) begin
            chk_cause = 2'd2;
        end else begin
            chk_cause = 2'd0;
        end
    end

    // Lane steering from the latched op.
    always_comb begin
        off       = addr_q[1:0];
        be        = 4'b1111;
        wdata_rep = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << off;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
        shifted = mem_rdata >> {off, 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        cause_d     = cause_q;
        // A completion seen in the last allowed cycle still wins over the timeout.
        timeout_hit = ({1'b0, cnt_q} + 9'd1) >= TIMEOUT_LIM;
        case (state_q)
            S_IDLE: begin
                if (cpu_valid) begin
                    we_d    = cpu_we;
                    f3_d    = cpu_funct3;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    rdata_d = 32'd0;
                    cnt_d   = 8'd0;
                    cause_d = chk_cause;
                    state_d = (chk_cause != 2'd0) ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_gnt) begin
                    state_d = we_q ? S_RESP : S_WAIT;
                end else if (timeout_hit) begin
                    cause_d = 2'd3;
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_rvalid) begin
                    rdata_d = load_ext;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    cause_d = 2'd3;
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            cnt_q   <= 8'd0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        cpu_ready  = (state_q == S_IDLE);
        mem_req    = (state_q == S_REQ);
        mem_we     = mem_req && we_q;
        mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_be     = mem_req ? be : 4'd0;
        mem_wdata  = mem_req ? wdata_rep : 32'd0;
        resp_valid = (state_q == S_RESP);
        resp_cause = resp_valid ? cause_q : 2'd0;
        resp_fault = resp_valid && (cause_q != 2'd0);
        resp_rdata = resp_valid ? rdata_q : 32'd0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized ops against a reference model, and reset/back-to-back sequences.
module tb_load_store_unit;

    localparam logic [31:0] DMEM_START = 32'h00200000;
    localparam logic [31:0] DMEM_END   = 32'h00250000;
    localparam int          TO         = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_valid, cpu_ready, cpu_we;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_cause;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_pass  = 0;
    int n_total = 0;

    load_store_unit #(
        .DMEM_START    (DMEM_START),
        .DMEM_END      (DMEM_END),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_valid (cpu_valid),
        .cpu_ready (cpu_ready),
        .cpu_we    (cpu_we),
        .cpu_funct3(cpu_funct3),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_fault(resp_fault),
        .resp_cause(resp_cause),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int          k;
        logic        fault;
        logic [1:0]  cause;
        logic [31:0] rdata;
        logic        req;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          gnt_k;
        int          rv_d;
        logic [31:0] rd;
        exp_t        e;
    } vec_t;

    typedef struct {
        int          resp_k;
        logic        fault;
        logic [1:0]  cause;
        logic [31:0] rdata;
        int          req_cycles;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] wdata;
        logic        mwe;
        logic        ready0;
        logic        busy_ready;
        logic        req_at_resp;
        logic        unstable;
    } obs_t;

    function automatic void chk(string tag, string what, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
    endfunction

    // Reference model: derived from the access rules, with cycle indices counted
    // from the accept edge (k=1 is the first cycle after accept).
    function automatic exp_t model(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                                   int gnt_k, int rv_d, logic [31:0] rd);
        exp_t e;
        bit legal;
        int n, o, limit, done;
        longint unsigned v;
        e = '{default: 0};
        o = int'(addr % 4);
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n = 1 << f3[1:0];
        if (!legal || (addr % n) != 0) begin
            e.k = 1; e.fault = 1'b1; e.cause = 2'd1;
            return e;
        end
        if (addr < DMEM_START || addr >= DMEM_END) begin
            e.k = 1; e.fault = 1'b1; e.cause = 2'd2;
            return e;
        end
        e.req = 1'b1;
        e.be  = 4'(((1 << n) - 1) << o);
        if (n == 1)      e.wdata = 32'(wd[7:0]) * 32'h01010101;
        else if (n == 2) e.wdata = 32'(wd[15:0]) * 32'h00010001;
        else             e.wdata = wd;
        if (gnt_k > TO) begin
            e.k = TO + 1; e.fault = 1'b1; e.cause = 2'd3;
            return e;
        end
        if (we) begin
            e.k = gnt_k + 1;
            return e;
        end
        limit = (gnt_k + 1 > TO) ? gnt_k + 1 : TO;
        done  = gnt_k + rv_d;
        if (done > limit) begin
            e.k = limit + 1; e.fault = 1'b1; e.cause = 2'd3;
            return e;
        end
        e.k = done + 1;
        v = (64'(rd) >> (8 * o)) & ((64'd1 << (8 * n)) - 64'd1);
        if (f3[2] == 1'b0 && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        e.rdata = v[31:0];
        return e;
    endfunction

    // Issues one op and plays the memory side: gnt once mem_req is seen at cycle >= gnt_k,
    // rvalid rv_d cycles after the grant.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int gnt_k, input int rv_d,
                          input logic [31:0] rd, output obs_t ob);
        int granted;
        ob = '{default: 0};
        granted = 0;
        @(negedge clk);
        ob.ready0  = cpu_ready;
        cpu_valid  = 1'b1;
        cpu_we     = we;
        cpu_funct3 = f3;
        cpu_addr   = addr;
        cpu_wdata  = wd;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            cpu_valid  = 1'b0;
            cpu_addr   = $urandom;
            cpu_wdata  = $urandom;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (cpu_ready) ob.busy_ready = 1'b1;
            if (mem_req) begin
                if (ob.req_cycles == 0) begin
                    ob.be = mem_be; ob.maddr = mem_addr; ob.wdata = mem_wdata; ob.mwe = mem_we;
                end else if (mem_be != ob.be || mem_addr != ob.maddr ||
                             mem_wdata != ob.wdata || mem_we != ob.mwe) begin
                    ob.unstable = 1'b1;
                end
                ob.req_cycles++;
            end
            if (resp_valid) begin
                ob.resp_k      = k;
                ob.fault       = resp_fault;
                ob.cause       = resp_cause;
                ob.rdata       = resp_rdata;
                ob.req_at_resp = mem_req;
                break;
            end
            if (mem_req && k >= gnt_k) begin
                mem_gnt = 1'b1;
                granted = k;
            end
            if (granted > 0 && !we && k == granted + rv_d) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
            end
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic check_op(string tag, logic we, logic [31:0] addr, exp_t e, obs_t ob);
        chk(tag, "ready_at_issue", 32'(ob.ready0), 32'd1);
        chk(tag, "resp_cycle", ob.resp_k, e.k);
        chk(tag, "fault", 32'(ob.fault), 32'(e.fault));
        chk(tag, "cause", 32'(ob.cause), 32'(e.cause));
        chk(tag, "rdata", ob.rdata, e.rdata);
        chk(tag, "ready_while_busy", 32'(ob.busy_ready), 32'd0);
        chk(tag, "req_at_resp", 32'(ob.req_at_resp), 32'd0);
        if (e.req) begin
            chk(tag, "req_seen", 32'(ob.req_cycles > 0), 32'd1);
            chk(tag, "be", 32'(ob.be), 32'(e.be));
            chk(tag, "mem_addr", ob.maddr, addr & 32'hFFFF_FFFC);
            chk(tag, "mem_we", 32'(ob.mwe), 32'(we));
            chk(tag, "req_stable", 32'(ob.unstable), 32'd0);
            if (we) chk(tag, "mem_wdata", ob.wdata, e.wdata);
        end else begin
            chk(tag, "no_req", ob.req_cycles, 0);
        end
    endtask

    task automatic chk_idle_outputs(string tag);
        chk(tag, "cpu_ready", 32'(cpu_ready), 32'd1);
        chk(tag, "resp_valid", 32'(resp_valid), 32'd0);
        chk(tag, "resp_rdata", resp_rdata, 32'd0);
        chk(tag, "resp_fault", 32'(resp_fault), 32'd0);
        chk(tag, "resp_cause", 32'(resp_cause), 32'd0);
        chk(tag, "mem_req", 32'(mem_req), 32'd0);
        chk(tag, "mem_we", 32'(mem_we), 32'd0);
        chk(tag, "mem_addr", mem_addr, 32'd0);
        chk(tag, "mem_be", 32'(mem_be), 32'd0);
        chk(tag, "mem_wdata", mem_wdata, 32'd0);
    endtask

    vec_t tbl[14];
    obs_t ob;
    exp_t e;

    initial begin
        // {we, f3, addr, wd, gnt_k, rv_d, rd, {k, fault, cause, rdata, req, be, wdata}}
        tbl[0]  = '{1'b1, 3'd2, 32'h00200004, 32'hDEADBEEF, 1, 1, 32'h0,        '{2, 1'b0, 2'd0, 32'h0,        1'b1, 4'b1111, 32'hDEADBEEF}};
        tbl[1]  = '{1'b1, 3'd0, 32'h00200007, 32'h000000A5, 1, 1, 32'h0,        '{2, 1'b0, 2'd0, 32'h0,        1'b1, 4'b1000, 32'hA5A5A5A5}};
        tbl[2]  = '{1'b0, 3'd0, 32'h00200007, 32'h0,        1, 1, 32'hA5000000, '{3, 1'b0, 2'd0, 32'hFFFFFFA5, 1'b1, 4'b1000, 32'h0}};
        tbl[3]  = '{1'b0, 3'd4, 32'h00200007, 32'h0,        1, 1, 32'hA5000000, '{3, 1'b0, 2'd0, 32'h000000A5, 1'b1, 4'b1000, 32'h0}};
        tbl[4]  = '{1'b0, 3'd1, 32'h00200002, 32'h0,        1, 1, 32'h80010000, '{3, 1'b0, 2'd0, 32'hFFFF8001, 1'b1, 4'b1100, 32'h0}};
        tbl[5]  = '{1'b0, 3'd5, 32'h00200002, 32'h0,        1, 1, 32'h80010000, '{3, 1'b0, 2'd0, 32'h00008001, 1'b1, 4'b1100, 32'h0}};
        tbl[6]  = '{1'b0, 3'd2, 32'h00200002, 32'h0,        1, 1, 32'h0,        '{1, 1'b1, 2'd1, 32'h0,        1'b0, 4'b0000, 32'h0}};
        tbl[7]  = '{1'b0, 3'd2, 32'h00000100, 32'h0,        1, 1, 32'h0,        '{1, 1'b1, 2'd2, 32'h0,        1'b0, 4'b0000, 32'h0}};
        tbl[8]  = '{1'b1, 3'd2, 32'h00250000, 32'h12345678, 1, 1, 32'h0,        '{1, 1'b1, 2'd2, 32'h0,        1'b0, 4'b0000, 32'h0}};
        tbl[9]  = '{1'b0, 3'd2, 32'h0024FFFC, 32'h0,        1, 1, 32'h12345678, '{3, 1'b0, 2'd0, 32'h12345678, 1'b1, 4'b1111, 32'h0}};
        tbl[10] = '{1'b0, 3'd2, 32'h00200000, 32'h0,      100, 1, 32'h0,        '{9, 1'b1, 2'd3, 32'h0,        1'b1, 4'b1111, 32'h0}};
        tbl[11] = '{1'b1, 3'd3, 32'h00200000, 32'h0,        1, 1, 32'h0,        '{1, 1'b1, 2'd1, 32'h0,        1'b0, 4'b0000, 32'h0}};
        tbl[12] = '{1'b0, 3'd6, 32'h00200000, 32'h0,        1, 1, 32'h0,        '{1, 1'b1, 2'd1, 32'h0,        1'b0, 4'b0000, 32'h0}};
        tbl[13] = '{1'b1, 3'd1, 32'h00200006, 32'h0000BEEF, 3, 1, 32'h0,        '{4, 1'b0, 2'd0, 32'h0,        1'b1, 4'b1100, 32'hBEEFBEEF}};

        rst = 1'b1; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_funct3 = 3'd0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].gnt_k, tbl[i].rv_d, tbl[i].rd, ob);
            check_op($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].e, ob);
        end

        // Reset while in WAIT, then rvalid pulses must be ignored.
        @(negedge clk);
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'd2; cpu_addr = 32'h00200000;
        @(negedge clk);
        cpu_valid = 1'b0;
        chk("rst_wait", "req_k1", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rst_wait", "in_wait_req", 32'(mem_req), 32'd0);
        chk("rst_wait", "in_wait_ready", 32'(cpu_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("rst_wait_after");
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rst_wait", "no_resp1", 32'(resp_valid), 32'd0);
        chk("rst_wait", "no_req1", 32'(mem_req), 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rst_wait", "no_resp2", 32'(resp_valid), 32'd0);

        // cpu_valid held through RESP: accepted only once back in IDLE.
        @(negedge clk);
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_funct3 = 3'd2; cpu_addr = 32'h00200010; cpu_wdata = 32'h11223344;
        @(negedge clk);
        chk("b2b", "req_k1", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("b2b", "resp_k2", 32'(resp_valid), 32'd1);
        chk("b2b", "ready_in_resp", 32'(cpu_ready), 32'd0);
        @(negedge clk);
        chk("b2b", "ready_idle", 32'(cpu_ready), 32'd1);
        chk("b2b", "no_req_idle", 32'(mem_req), 32'd0);
        @(negedge clk);
        cpu_valid = 1'b0;
        chk("b2b", "second_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("b2b", "second_resp", 32'(resp_valid), 32'd1);

        for (int i = 0; i < 150; i++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr, wd, rd;
            int          gk, rv;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0, 1:    addr = DMEM_START + 32'($urandom_range(0, 32'h0000FFFF));
                2:       addr = DMEM_END - 32'($urandom_range(1, 8));
                3:       addr = DMEM_END + 32'($urandom_range(0, 7));
                4:       addr = DMEM_START - 32'($urandom_range(1, 8));
                default: addr = $urandom;
            endcase
            wd = $urandom;
            rd = $urandom;
            gk = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(1, 5));
            rv = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(1, 3));
            e = model(we, f3, addr, wd, gk, rv, rd);
            run_op(we, f3, addr, wd, gk, rv, rd, ob);
            check_op($sformatf("rnd%0d", i), we, addr, e, ob);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle load/store unit between the RV32I datapath and a handshaked data memory; replaces direct byte-array access to DMEM.
- Accepts one memory op from the core (address = ALU result, store data = rs2, size/sign = funct3). Produces byte enables, aligned word requests, sign/zero-extended load data, and fault status.
- The core stalls from acceptance until the response is returned.

Parameters:
- DMEM_START, 32'h00200000, first legal data address (inclusive, word-aligned).
- DMEM_END, 32'h00250000, end of the legal data range (exclusive, word-aligned).
- TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before a bus-timeout fault (8-bit counter, 1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_valid  in  1  op request; held with stable fields until accepted.
- cpu_ready  out  1  high in IDLE; accept = cpu_valid & cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_funct3  in  3  RV32I load/store funct3.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  op failed; no memory side effect.
- resp_cause  out  2  0 none, 1 misaligned/illegal funct3, 2 out of range, 3 bus timeout.
- mem_req  out  1  memory request; held until mem_gnt.
- mem_we  out  1  write strobe qualifier.
- mem_addr  out  32  word address {cpu_addr[31:2],2'b00}.
- mem_be  out  4  byte enables (bit i = byte lane i).
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid (loads only, at least one cycle after gnt).
- mem_rdata  in  32  read word.

Behaviour:
- Reset (synchronous, on rst high at a clk edge): state IDLE; every output 0 except cpu_ready = 1; timeout counter 0. Reset mid-op aborts it: mem_req drops next cycle and no resp_valid is issued.
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE: on accept, latch all cpu_* fields and check.
    - Illegal funct3 (loads 011/110/111; stores anything other than 000/001/010) -> cause 1.
    - Halfword with addr[0] = 1, or word with addr[1:0] != 0 -> cause 1.
    - Else addr < DMEM_START or addr >= DMEM_END -> cause 2.
    - Any fault -> RESP. Otherwise -> REQ.
  - REQ: mem_req = 1 with stable mem_* outputs.
    - On mem_gnt: store -> RESP; load -> WAIT.
  - WAIT: on mem_rvalid, capture and extend data -> RESP.
  - RESP: resp_valid = 1 for exactly one cycle -> IDLE. cpu_ready = 0 in every state except IDLE.
- Timeout: counter clears on accept and increments each cycle in REQ/WAIT. At TIMEOUT_CYCLES -> RESP with cause 3, mem_req deasserted. mem_rvalid/mem_gnt are ignored outside REQ/WAIT.
- Byte enables, with o = addr[1:0]:
  - SB/LB/LBU: be = 4'b0001<<o.
  - SH/LH/LHU: be = 4'b0011<<o.
  - SW/LW: be = 4'b1111.
  - Loads drive be too; mem_we = 0 for loads.
- Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- Load extract:
  - Byte = rdata[8*o+7:8*o]; halfword = rdata[8*o+15:8*o].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Latency (gnt in first REQ cycle):
  - Store: accept at T, REQ at T+1, resp_valid at T+2.
  - Load with rvalid at T+2: resp_valid at T+3.
  - Fault: resp_valid at T+1, no mem_req ever asserted.
- Back-to-back: next accept possible in the cycle after RESP.
- cpu_valid high during RESP is not accepted until IDLE.

Test Plan:
- Reset, then SW addr 0x00200004 data 0xDEADBEEF with gnt immediate -> mem_req at T+1, be=1111, mem_addr 0x00200004, resp_valid at T+2, fault 0.
- SB addr 0x00200007 data 0x000000A5 -> be=1000, mem_wdata 0xA5A5A5A5. Then LB from the same addr with rdata 0xA5000000, rvalid at T+2 -> resp_rdata 0xFFFFFFA5 at T+3. LBU -> 0x000000A5.
- LH addr 0x00200002, rdata 0x80010000 -> 0xFFFF8001; LHU -> 0x00008001; LW addr 0x00200002 -> fault cause 1 at T+1, no mem_req.
- LW addr 0x00000100 -> cause 2. SW addr 0x00250000 -> cause 2. LW addr 0x0024FFFC -> legal, mem_req asserted.
- Load with mem_gnt never asserted, TIMEOUT_CYCLES=8 -> resp_valid, cause 3, 8 cycles after entering REQ; mem_req low afterwards.
- rst asserted in WAIT, then rvalid pulses -> no resp_valid, all outputs 0, cpu_ready=1 the cycle after reset.
